ctrl_unit: RTL and testbench
============================

CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk_ctrl  in  1  single clock; all state updates on rising edge.
REQ-003 rst_ctrl  in  1  asynchronous, active-low reset.
REQ-004 pc_ctrl  out  8  program-memory address, registered.
REQ-005 instr_ctrl  in  8  program byte at pc_ctrl, combinational read, valid in the same cycle.
REQ-006 muxsel_ctrl  out  2  datapath source select: 00 shifter, 01 reg file, 10 input, 11 immediate.
REQ-007 imm_ctrl  out  8  immediate byte; always equals the operand register.
REQ-008 accwr_ctrl  out  1  accumulator write strobe.
REQ-009 rfaddr_ctrl  out  3  register-file address.
REQ-010 rfwr_ctrl  out  1  register-file write strobe.
REQ-011 alusel_ctrl  out  3  ALU operation select.
REQ-012 shiftsel_ctrl  out  2  shifter select.
REQ-013 outen_ctrl  out  1  output tristate enable.
REQ-014 zero_ctrl, positive_ctrl  in  1 each  datapath flags computed from the current mux output.
REQ-015 in_valid_ctrl  in  1  external input data valid; in_ack_ctrl  out  1  input consumed.
REQ-016 halted_ctrl  out  1  high while in HALT.

Function
REQ-017 Encoding SHALL be: IR[7:4] opcode, IR[3:0] field; OP is the second-byte register.
REQ-018 Opcodes SHALL be:
- 0x0 NOP
- 0x1 LDA r (A<-R[IR[2:0]])
- 0x2 STA r (R[IR[2:0]]<-A)
- 0x3 LDI #OP
- 0x4 IN
- 0x5 OUT
- 0x6 ALU: alusel=IR[2:0], r=OP[2:0], shiftsel=OP[4:3]
- 0x7 JMP OP
- 0x8 JZ OP
- 0x9 JP OP
- 0xF HALT
- All other opcodes SHALL execute as NOP.
REQ-019 Two-byte opcodes SHALL be 0x3, 0x6, 0x7, 0x8, 0x9; all others SHALL be one byte.
REQ-020 FSM states SHALL be FETCH, DECODE, FETCH2, EXEC, HALT.
REQ-021 FETCH SHALL set IR<=instr_ctrl and pc<=pc+1, then go to DECODE.
REQ-022 DECODE SHALL go to FETCH2 if the opcode is two-byte, else to EXEC; 0xF SHALL go to HALT.
REQ-023 FETCH2 SHALL set OP<=instr_ctrl and pc<=pc+1, then go to EXEC.
REQ-024 EXEC SHALL go to FETCH after exactly one cycle, except for the IN stall (REQ-029).
REQ-025 Instruction latency SHALL be 3 cycles for one-byte and 4 cycles for two-byte instructions, IN stall excluded.
REQ-026 pc SHALL increment modulo 256 (0xFF+1=0x00).
REQ-027 Outside EXEC, accwr, rfwr, outen and in_ack SHALL be 0; muxsel and shiftsel SHALL be 00; alusel SHALL be IR[2:0]; rfaddr SHALL be IR[2:0].
REQ-028 EXEC strobes SHALL be:
- LDA: muxsel=01, accwr=1
- STA: rfwr=1
- LDI: muxsel=11, accwr=1
- OUT: outen=1
- ALU: rfaddr=OP[2:0], muxsel=00, accwr=1, i.e. A<=shift(alu(A,R[r]))
REQ-029 IN SHALL hold EXEC with all strobes 0 while in_valid_ctrl=0.
REQ-030 IN with in_valid_ctrl=1 SHALL assert muxsel=10, accwr=1 and in_ack_ctrl=1 in the same cycle, then go to FETCH.
REQ-031 Internal flags Z and P SHALL load zero_ctrl and positive_ctrl on every edge where accwr_ctrl=1, and hold otherwise.
REQ-032 In EXEC, JMP SHALL load pc<=OP; JZ SHALL load pc<=OP if Z=1; JP SHALL load pc<=OP if P=1; an untaken branch SHALL leave pc unchanged.
REQ-033 HALT SHALL hold pc and all strobes at 0 and keep halted_ctrl=1; only reset exits HALT.
REQ-034 All strobes SHALL be combinational from state, IR, OP and in_valid_ctrl, and glitch-free relative to clk_ctrl edges.

Reset
REQ-035 While rst_ctrl=0, the block SHALL force state=FETCH, pc=0x00, IR=0x00, OP=0x00, Z=1, P=1.
REQ-036 While rst_ctrl=0, all strobes SHALL be 0, halted_ctrl=0, and imm_ctrl=0x00.
REQ-037 Assertion of rst_ctrl SHALL take effect immediately, including mid-EXEC, mid-stall or in HALT.
REQ-038 After rst_ctrl deasserts, the first fetch SHALL occur at address 0x00.

Verification
REQ-039 Reset: assert rst_ctrl low during the EXEC of LDI -> accwr=0 at once, pc=0x00, Z=1, P=1; release -> FETCH at pc 0x00.
REQ-040 LDI: program 0x30,0x05 -> the 4th cycle after reset shows muxsel=11, imm=0x05, accwr=1; pc=0x02 afterwards.
REQ-041 Branches:
- LDI 0x00 then JZ 0x10 -> pc=0x10.
- LDI 0x05 then JZ 0x10 -> pc=0x04.
- LDI 0x80 then JP 0x20 -> branch not taken.
REQ-042 IN stall: in_valid_ctrl low for 3 cycles -> EXEC held, accwr=0; on cycle 4 it goes high -> accwr=1, muxsel=10, in_ack=1 for exactly one cycle.
REQ-043 HALT: opcode 0xF0 -> halted_ctrl=1, pc frozen and no strobes for 20 cycles; reset -> resume at 0x00.
REQ-044 Wrap: NOP at 0xFF -> the next fetch is at 0x00; JMP whose operand byte sits at 0xFF -> OP is read correctly and pc=OP.

Source files
------------

// File: rtl/ctrl_unit.sv
// Multi-cycle controller for an 8-bit accumulator CPU: fetches 1- or 2-byte
// instructions, sequences FETCH/DECODE/FETCH2/EXEC and drives datapath strobes.
module ctrl_unit (
  input  logic       clk_ctrl,
  input  logic       rst_ctrl,
  output logic [7:0] pc_ctrl,
  input  logic [7:0] instr_ctrl,
  output logic [1:0] muxsel_ctrl,
  output logic [7:0] imm_ctrl,
  output logic       accwr_ctrl,
  output logic [2:0] rfaddr_ctrl,
  output logic       rfwr_ctrl,
  output logic [2:0] alusel_ctrl,
  output logic [1:0] shiftsel_ctrl,
  output logic       outen_ctrl,
  input  logic       zero_ctrl,
  input  logic       positive_ctrl,
  input  logic       in_valid_ctrl,
  output logic       in_ack_ctrl,
  output logic       halted_ctrl
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_FETCH2 = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_STA  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_IN   = 4'h4;
  localparam logic [3:0] OP_OUT  = 4'h5;
  localparam logic [3:0] OP_ALU  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JP   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic [7:0] r_ir, r_op;
  logic       r_z, r_p;
  logic [3:0] w_opc;
  logic       w_two_byte;

  assign w_opc      = r_ir[7:4];
  assign w_two_byte = (w_opc == OP_LDI) || (w_opc == OP_ALU) || (w_opc == OP_JMP) ||
                      (w_opc == OP_JZ)  || (w_opc == OP_JP);

  always_ff @(posedge clk_ctrl or negedge rst_ctrl) begin
    if (!rst_ctrl) begin
      r_state <= S_FETCH;
      r_pc    <= 8'h00;
      r_ir    <= 8'h00;
      r_op    <= 8'h00;
      r_z     <= 1'b1;
      r_p     <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (r_state == S_FETCH)  r_ir <= instr_ctrl;
      if (r_state == S_FETCH2) r_op <= instr_ctrl;
      if (accwr_ctrl) begin
        r_z <= zero_ctrl;
        r_p <= positive_ctrl;
      end
    end
  end

  // Sequencing and pc update; pc wraps naturally in 8 bits.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      S_FETCH: begin
        w_pc_nxt    = r_pc + 8'd1;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (w_opc == OP_HALT)  w_state_nxt = S_HALT;
        else if (w_two_byte)   w_state_nxt = S_FETCH2;
        else                   w_state_nxt = S_EXEC;
      end
      S_FETCH2: begin
        w_pc_nxt    = r_pc + 8'd1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        if (w_opc == OP_IN && !in_valid_ctrl) w_state_nxt = S_EXEC;
        if ((w_opc == OP_JMP) || (w_opc == OP_JZ && r_z) || (w_opc == OP_JP && r_p))
          w_pc_nxt = r_op;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Strobes are decoded only from registered state plus in_valid.
  always_comb begin
    muxsel_ctrl   = 2'b00;
    accwr_ctrl    = 1'b0;
    rfwr_ctrl     = 1'b0;
    outen_ctrl    = 1'b0;
    in_ack_ctrl   = 1'b0;
    shiftsel_ctrl = 2'b00;
    rfaddr_ctrl   = r_ir[2:0];
    alusel_ctrl   = r_ir[2:0];
    if (r_state == S_EXEC) begin
      unique case (w_opc)
        OP_LDA: begin muxsel_ctrl = 2'b01; accwr_ctrl = 1'b1; end
        OP_STA: rfwr_ctrl = 1'b1;
        OP_LDI: begin muxsel_ctrl = 2'b11; accwr_ctrl = 1'b1; end
        OP_IN: if (in_valid_ctrl) begin
          muxsel_ctrl = 2'b10;
          accwr_ctrl  = 1'b1;
          in_ack_ctrl = 1'b1;
        end
        OP_OUT: outen_ctrl = 1'b1;
        OP_ALU: begin
          rfaddr_ctrl   = r_op[2:0];
          shiftsel_ctrl = r_op[4:3];
          accwr_ctrl    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_ctrl     = r_pc;
  assign imm_ctrl    = r_op;
  assign halted_ctrl = (r_state == S_HALT);

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: per-opcode vector table plus hand sequences
// for reset-in-EXEC, branches, IN stall, HALT and pc wrap.
module tb_ctrl_unit;

  logic       clk_ctrl = 1'b0;
  logic       rst_ctrl = 1'b0;
  logic [7:0] pc_ctrl, instr_ctrl, imm_ctrl;
  logic [1:0] muxsel_ctrl, shiftsel_ctrl;
  logic       accwr_ctrl, rfwr_ctrl, outen_ctrl, in_ack_ctrl, halted_ctrl;
  logic [2:0] rfaddr_ctrl, alusel_ctrl;
  logic       zero_ctrl, positive_ctrl;
  logic       in_valid_ctrl = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] mem [256];
  logic [7:0] w_mux;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_ctrl = ~clk_ctrl;

  // Program memory and a minimal datapath flag model (LDI/IN sources only).
  assign instr_ctrl    = mem[pc_ctrl];
  assign w_mux         = (muxsel_ctrl == 2'b11) ? imm_ctrl :
                         (muxsel_ctrl == 2'b10) ? in_data : 8'h00;
  assign zero_ctrl     = (w_mux == 8'h00);
  assign positive_ctrl = (w_mux != 8'h00) && !w_mux[7];

  ctrl_unit dut (
    .clk_ctrl(clk_ctrl), .rst_ctrl(rst_ctrl), .pc_ctrl(pc_ctrl), .instr_ctrl(instr_ctrl),
    .muxsel_ctrl(muxsel_ctrl), .imm_ctrl(imm_ctrl), .accwr_ctrl(accwr_ctrl),
    .rfaddr_ctrl(rfaddr_ctrl), .rfwr_ctrl(rfwr_ctrl), .alusel_ctrl(alusel_ctrl),
    .shiftsel_ctrl(shiftsel_ctrl), .outen_ctrl(outen_ctrl), .zero_ctrl(zero_ctrl),
    .positive_ctrl(positive_ctrl), .in_valid_ctrl(in_valid_ctrl),
    .in_ack_ctrl(in_ack_ctrl), .halted_ctrl(halted_ctrl)
  );

  typedef struct {
    logic [7:0] b0, b1;
    int         ncyc;
    logic [1:0] mux;
    logic       accwr, rfwr, outen;
    logic [2:0] rfaddr;
    logic [1:0] shsel;
    logic [2:0] alusel;
    logic [7:0] imm;
    logic [7:0] pc_nxt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [21:0] outs();
    return {muxsel_ctrl, accwr_ctrl, rfwr_ctrl, outen_ctrl, rfaddr_ctrl,
            shiftsel_ctrl, alusel_ctrl, imm_ctrl, in_ack_ctrl};
  endfunction

  function automatic logic [7:0] strobes();
    return {accwr_ctrl, rfwr_ctrl, outen_ctrl, in_ack_ctrl, muxsel_ctrl, shiftsel_ctrl};
  endfunction

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  // Leaves the bench at a negedge with the DUT in FETCH, cycle 1.
  task automatic do_reset();
    @(negedge clk_ctrl); rst_ctrl = 1'b0;
    @(negedge clk_ctrl); rst_ctrl = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_ctrl);
  endtask

  initial begin
    int bad;
    //          b0     b1     n  mux  acc rf  out rfa   sh     alu   imm    pc_nxt
    tbl[0] = '{8'h00, 8'h00, 3, 2'b00, 0, 0, 0, 3'd0, 2'b00, 3'd0, 8'h00, 8'h01}; // NOP
    tbl[1] = '{8'h13, 8'h00, 3, 2'b01, 1, 0, 0, 3'd3, 2'b00, 3'd3, 8'h00, 8'h01}; // LDA r3
    tbl[2] = '{8'h25, 8'h00, 3, 2'b00, 0, 1, 0, 3'd5, 2'b00, 3'd5, 8'h00, 8'h01}; // STA r5
    tbl[3] = '{8'h30, 8'h05, 4, 2'b11, 1, 0, 0, 3'd0, 2'b00, 3'd0, 8'h05, 8'h02}; // LDI #5
    tbl[4] = '{8'h50, 8'h00, 3, 2'b00, 0, 0, 1, 3'd0, 2'b00, 3'd0, 8'h00, 8'h01}; // OUT
    tbl[5] = '{8'h66, 8'h1A, 4, 2'b00, 1, 0, 0, 3'd2, 2'b11, 3'd6, 8'h1A, 8'h02}; // ALU
    tbl[6] = '{8'h70, 8'h42, 4, 2'b00, 0, 0, 0, 3'd0, 2'b00, 3'd0, 8'h42, 8'h42}; // JMP
    tbl[7] = '{8'hA5, 8'h00, 3, 2'b00, 0, 0, 0, 3'd5, 2'b00, 3'd5, 8'h00, 8'h01}; // unused op
    tbl[8] = '{8'h80, 8'h10, 4, 2'b00, 0, 0, 0, 3'd0, 2'b00, 3'd0, 8'h10, 8'h10}; // JZ, Z=1
    tbl[9] = '{8'h90, 8'h33, 4, 2'b00, 0, 0, 0, 3'd0, 2'b00, 3'd0, 8'h33, 8'h33}; // JP, P=1

    clear_mem();
    @(negedge clk_ctrl); #1;
    chk("reset_pc",     32'(pc_ctrl), 32'h00);
    chk("reset_strobe", 32'(strobes()), 32'h00);
    chk("reset_halted", 32'(halted_ctrl), 32'h0);
    chk("reset_imm",    32'(imm_ctrl), 32'h00);

    for (int i = 0; i < 10; i++) begin
      clear_mem();
      mem[0] = tbl[i].b0;
      mem[1] = tbl[i].b1;
      do_reset();
      chk($sformatf("vec%0d_first_pc", i), 32'(pc_ctrl), 32'h00);
      step(tbl[i].ncyc - 1);
      chk($sformatf("vec%0d_exec", i), 32'(outs()),
          32'({tbl[i].mux, tbl[i].accwr, tbl[i].rfwr, tbl[i].outen, tbl[i].rfaddr,
               tbl[i].shsel, tbl[i].alusel, tbl[i].imm, 1'b0}));
      step(1);
      chk($sformatf("vec%0d_pc", i), 32'(pc_ctrl), 32'(tbl[i].pc_nxt));
    end

    // Reset during LDI EXEC after Z was cleared; JZ afterwards must be taken.
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'h05; mem[2] = 8'h30; mem[3] = 8'h07;
    do_reset();
    step(7);
    chk("rst_pre_accwr", 32'(accwr_ctrl), 32'h1);
    #2 rst_ctrl = 1'b0;
    #1;
    chk("rst_mid_accwr", 32'(accwr_ctrl), 32'h0);
    chk("rst_mid_pc",    32'(pc_ctrl), 32'h00);
    chk("rst_mid_imm",   32'(imm_ctrl), 32'h00);
    @(negedge clk_ctrl);
    mem[0] = 8'h80; mem[1] = 8'h10;
    @(negedge clk_ctrl); rst_ctrl = 1'b1;
    chk("rst_rel_pc", 32'(pc_ctrl), 32'h00);
    step(4);
    chk("rst_z_set_jz", 32'(pc_ctrl), 32'h10);

    // Branches on loaded flags.
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'h00; mem[2] = 8'h80; mem[3] = 8'h10;
    do_reset(); step(8);
    chk("jz_taken", 32'(pc_ctrl), 32'h10);
    mem[1] = 8'h05;
    do_reset(); step(8);
    chk("jz_not_taken", 32'(pc_ctrl), 32'h04);
    mem[1] = 8'h80; mem[2] = 8'h90; mem[3] = 8'h20;
    do_reset(); step(8);
    chk("jp_not_taken", 32'(pc_ctrl), 32'h04);

    // IN stall: three EXEC cycles without valid, then accept.
    clear_mem();
    mem[0] = 8'h40;
    in_valid_ctrl = 1'b0;
    in_data = 8'h3C;
    do_reset(); step(2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("in_stall%0d_strobe", k), 32'(strobes()), 32'h00);
      chk($sformatf("in_stall%0d_pc", k), 32'(pc_ctrl), 32'h01);
      step(1);
    end
    in_valid_ctrl = 1'b1;
    #1;
    chk("in_accept", 32'({accwr_ctrl, muxsel_ctrl, in_ack_ctrl}), 32'b1101);
    step(1);
    chk("in_ack_once", 32'(in_ack_ctrl), 32'h0);
    chk("in_next_pc",  32'(pc_ctrl), 32'h01);
    in_valid_ctrl = 1'b0;

    // HALT holds for 20 cycles; only reset leaves it.
    clear_mem();
    mem[0] = 8'hF0;
    do_reset(); step(2);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (halted_ctrl !== 1'b1 || pc_ctrl !== 8'h01 || strobes() !== 8'h00) bad++;
      step(1);
    end
    chk("halt_hold_bad_cycles", 32'(bad), 32'h0);
    rst_ctrl = 1'b0;
    #1;
    chk("halt_rst_halted", 32'(halted_ctrl), 32'h0);
    chk("halt_rst_pc",     32'(pc_ctrl), 32'h00);
    mem[0] = 8'h00;
    @(negedge clk_ctrl); rst_ctrl = 1'b1;
    step(1);
    chk("halt_resume_pc", 32'(pc_ctrl), 32'h01);
    chk("halt_resume_st", 32'(halted_ctrl), 32'h0);

    // pc wrap: NOP at 0xFF, then JMP whose operand byte is at 0xFF.
    clear_mem();
    mem[0] = 8'h70; mem[1] = 8'hFF;
    do_reset(); step(4);
    chk("wrap_jmp_ff", 32'(pc_ctrl), 32'hFF);
    step(1);
    chk("wrap_pc_00", 32'(pc_ctrl), 32'h00);
    step(2);
    chk("wrap_next_fetch", 32'(pc_ctrl), 32'h00);
    clear_mem();
    mem[0] = 8'h70; mem[1] = 8'hFE; mem[8'hFE] = 8'h70; mem[8'hFF] = 8'h55;
    do_reset(); step(4);
    chk("wrap2_pc_fe", 32'(pc_ctrl), 32'hFE);
    step(3);
    chk("wrap2_imm", 32'(imm_ctrl), 32'h55);
    chk("wrap2_pc_exec", 32'(pc_ctrl), 32'h00);
    step(1);
    chk("wrap2_pc_op", 32'(pc_ctrl), 32'h55);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
